// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle between a master (bridge or bench) and apb_mem_slave.
// Latency: none, this is wiring only.
// Backpressure: the slave stretches the access phase by holding pready low.
// Signals: psel/penable/pwrite/paddr/pwdata/pstrb come from the master;
//          prdata/pready/pslverr come from the slave.
interface apb_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB4 memory slave: DEPTH words of DATA_W bits with byte strobes and range errors.
// Latency: 2 + WAIT_STATES cycles from setup-phase edge to completion edge.
// Backpressure: pready held low for WAIT_STATES access cycles, then high for one.
// Ports: pclk, preset (async, active-high) are plain; the APB signals
//        (psel, penable, pwrite, paddr, pwdata, pstrb -> prdata, pready,
//        pslverr) travel on the apb_mem_slave_if slave modport.
module apb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic            pclk,
  input  logic            preset,
  apb_mem_slave_if.slave  bus
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Registered state
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       strb_q, strb_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  // Decode of the live address for the setup-phase latch
  logic [ADDR_W-1:0]   word_addr;
  logic                out_of_range;
  logic                ready_c;

  assign word_addr    = bus.paddr >> OFF_W;
  assign out_of_range = (word_addr >= ADDR_W'(DEPTH));

  // Completion cycle: the master is in access phase and the wait count is spent.
  assign ready_c = (state_q == ACCESS) && bus.psel && bus.penable && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end

    unique case (state_q)
      IDLE: begin
        // psel with penable already high here is an access without setup:
        // ignored entirely, nothing is latched or written.
        if (bus.psel && !bus.penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = word_addr[IDX_W-1:0];
          wr_d    = bus.pwrite;
          err_d   = out_of_range;
          wdata_d = bus.pwdata;
          strb_d  = bus.pstrb;
        end
      end

      ACCESS: begin
        if (!bus.psel) begin
          // Master abandoned the transfer: no write, no response.
          state_d = IDLE;
        end else if (!bus.penable) begin
          // A fresh setup phase before completion restarts with the new request.
          cnt_d   = 4'(WAIT_STATES);
          idx_d   = word_addr[IDX_W-1:0];
          wr_d    = bus.pwrite;
          err_d   = out_of_range;
          wdata_d = bus.pwdata;
          strb_d  = bus.pstrb;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          // Writes commit on the completion edge; out-of-range writes are dropped.
          if (wr_q && !err_q) begin
            for (int b = 0; b < NB; b++) begin
              if (strb_q[b]) begin
                mem_d[idx_q][b*8 +: 8] = wdata_q[b*8 +: 8];
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Outputs come straight from registered state, so reset clears them at once.
  // Read data is forced to zero outside a good read completion.
  assign bus.pready  = ready_c;
  assign bus.pslverr = ready_c && err_q;
  assign bus.prdata  = (ready_c && !wr_q && !err_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_apb_mem_slave.sv
module tb_apb_mem_slave;

  localparam int SLOW_WS = 2;
  localparam int DEPTH   = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;

  always #5 pclk = ~pclk;

  apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if_f ();
  apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if_s ();

  assign if_f.psel    = psel;
  assign if_f.penable = penable;
  assign if_f.pwrite  = pwrite;
  assign if_f.paddr   = paddr;
  assign if_f.pwdata  = pwdata;
  assign if_f.pstrb   = pstrb;
  assign if_s.psel    = psel;
  assign if_s.penable = penable;
  assign if_s.pwrite  = pwrite;
  assign if_s.paddr   = paddr;
  assign if_s.pwdata  = pwdata;
  assign if_s.pstrb   = pstrb;

  // Both slaves share the bus; each transfer is held until the slow one
  // completes, after which the fast one just sees an ignored access.
  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_fast (
    .pclk(pclk), .preset(preset), .bus(if_f)
  );
  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(SLOW_WS)) u_slow (
    .pclk(pclk), .preset(preset), .bus(if_s)
  );

  int total = 0;
  int bad   = 0;

  // Reference storage: plain word array, updated byte by byte.
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    int idx = int'(a >> 2);
    if (idx < DEPTH) return ref_mem[idx];
    return 32'h0;
  endfunction

  function automatic logic mdl_err(input logic [31:0] a);
    return (a >> 2) >= 32'(DEPTH);
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a >> 2);
    if (idx < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic go_idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // One full transfer; bus fields are scrambled after setup to prove only the
  // setup-phase values matter.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        rdy;
    rd = (w || exp_err) ? 32'h0 : exp_rd;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    for (int c = 1; c <= SLOW_WS + 1; c++) begin
      @(posedge pclk); #1;
      penable = 1'b1;
      pwrite  = 1'($urandom());
      paddr   = $urandom();
      pwdata  = $urandom();
      pstrb   = 4'($urandom());
      @(negedge pclk);
      if (c == 1) begin
        chk("fast_pready",  32'(if_f.pready), 32'd1);
        chk("fast_pslverr", 32'(if_f.pslverr), 32'(exp_err));
        chk("fast_prdata",  if_f.prdata, rd);
      end else begin
        chk("fast_idle_pready", 32'(if_f.pready), 32'd0);
      end
      rdy = (c == SLOW_WS + 1);
      chk("slow_pready",  32'(if_s.pready), 32'(rdy));
      chk("slow_pslverr", 32'(if_s.pslverr), 32'(rdy && exp_err));
      chk("slow_prdata",  if_s.prdata, rdy ? rd : 32'h0);
    end
  endtask

  task automatic xfer_mdl(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    xfer(w, a, d, s, mdl_read(a), mdl_err(a));
    if (w) mdl_write(a, d, s);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    tbl[1]  = '{1'b0, 32'h08, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h00, 32'h1122_3344, 4'hF, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 32'h00, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0};
    tbl[4]  = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    tbl[5]  = '{1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0,         1'b1};
    tbl[6]  = '{1'b0, 32'h40, 32'h0,         4'h0, 32'h0,         1'b1};
    tbl[7]  = '{1'b0, 32'h00, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
    tbl[8]  = '{1'b0, 32'h04, 32'h0,         4'h0, 32'h0,         1'b0};
    tbl[9]  = '{1'b1, 32'h3C, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0};
    tbl[10] = '{1'b0, 32'h3F, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    tbl[11] = '{1'b0, 32'h0A, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[12] = '{1'b1, 32'h44, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};

    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    preset = 1'b1;
    mdl_clear();
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_fast_pready",  32'(if_f.pready), 32'd0);
    chk("rst_slow_pready",  32'(if_s.pready), 32'd0);
    chk("rst_slow_pslverr", 32'(if_s.pslverr), 32'd0);
    chk("rst_slow_prdata",  if_s.prdata, 32'h0);
    preset = 1'b0;

    // Directed table, back to back with no idle cycles
    for (int i = 0; i < 13; i++) begin
      xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].exp_rd, tbl[i].exp_err);
      if (tbl[i].w) mdl_write(tbl[i].a, tbl[i].d, tbl[i].s);
    end
    go_idle();

    // Abort: psel dropped in the first access cycle of a write
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h5555_AAAA; pstrb = 4'hF;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b1;
    @(negedge pclk);
    chk("abort_fast_pready", 32'(if_f.pready), 32'd0);
    chk("abort_slow_pready", 32'(if_s.pready), 32'd0);
    go_idle();
    xfer_mdl(1'b0, 32'h20, 32'h0, 4'h0);

    // Access without setup from IDLE
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h24; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      chk("viol_fast_pready", 32'(if_f.pready), 32'd0);
      chk("viol_slow_pready", 32'(if_s.pready), 32'd0);
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    xfer_mdl(1'b0, 32'h24, 32'h0, 4'h0);

    // Reset during the completion cycle of a read of word 3
    xfer_mdl(1'b1, 32'h0C, 32'h5A5A_5A5A, 4'hF);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0C;
    for (int c = 1; c <= SLOW_WS + 1; c++) begin
      @(posedge pclk); #1;
      penable = 1'b1;
    end
    @(negedge pclk);
    chk("prerst_slow_pready", 32'(if_s.pready), 32'd1);
    chk("prerst_slow_prdata", if_s.prdata, 32'h5A5A_5A5A);
    #1 preset = 1'b1;
    #1;
    chk("midrst_slow_pready",  32'(if_s.pready), 32'd0);
    chk("midrst_slow_pslverr", 32'(if_s.pslverr), 32'd0);
    chk("midrst_slow_prdata",  if_s.prdata, 32'h0);
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    mdl_clear();
    xfer_mdl(1'b0, 32'h0C, 32'h0, 4'h0);
    xfer_mdl(1'b0, 32'h08, 32'h0, 4'h0);

    // Random traffic against the reference storage, including out-of-range
    // words, odd byte offsets, partial strobes and occasional idle gaps.
    for (int n = 0; n < 250; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, DEPTH + 3)) * 32'd4 + 32'($urandom_range(0, 3));
      xfer_mdl(1'($urandom()), a, $urandom(), 4'($urandom()));
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    // Final sweep of every word
    for (int i = 0; i < DEPTH; i++) begin
      xfer_mdl(1'b0, 32'(i) * 32'd4, 32'h0, 4'h0);
    end
    go_idle();
    repeat (2) @(posedge pclk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
Name: apb_mem_slave

Overview:
Parametrised APB4 memory-mapped slave, the successor to the single-width register-file slave. It replaces the combinational, zero-wait model with a clocked access FSM and adds programmable wait states, byte strobes and error reporting. It sits behind the AHB-to-APB bridge as a generic storage or peripheral stub, with configurable data width, depth and latency.

Parameters:
DATA_W, 32, data bus width in bits; must be a multiple of 8.
ADDR_W, 32, APB address width in bits.
DEPTH, 16, number of DATA_W-bit words of storage.
WAIT_STATES, 0, extra access-phase cycles inserted before pready asserts; range 0..15.

Ports:
pclk  input  1  APB clock; all state changes on the rising edge.
preset  input  1  asynchronous reset, active-high.
psel  input  1  slave select.
penable  input  1  access-phase indicator.
pwrite  input  1  1 = write, 0 = read.
paddr  input  ADDR_W  byte address.
pwdata  input  DATA_W  write data.
pstrb  input  DATA_W/8  write byte strobes; ignored on reads.
prdata  output  DATA_W  read data.
pready  output  1  transfer-complete indicator.
pslverr  output  1  error response; valid only while pready=1.

Behaviour:
- Clock and reset: one clock (pclk). preset is asynchronous, active-high.
- Reset values:
  - FSM returns to IDLE; wait counter = 0; latched address, control and strobes = 0.
  - All mem words = 0.
  - pready = 0, pslverr = 0, prdata = 0.
- Word index: idx = paddr >> log2(DATA_W/8). Byte-offset bits are ignored; there is no misalignment error.
- Range check: idx >= DEPTH is out of range.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS when psel=1 and penable=0 (setup phase). On that edge: latch idx, pwrite, pwdata, pstrb and the range flag; load the counter with WAIT_STATES.
  - In ACCESS with psel=1 and penable=1:
    - If counter != 0: decrement the counter; pready = 0.
    - If counter == 0: pready = 1 this cycle, and the transfer completes on the next edge.
  - On completion, ACCESS -> IDLE.
  - If psel=0 while in ACCESS (aborted transfer): ACCESS -> IDLE, with no write and no response.
- Outputs are decoded from registered state:
  - pready = (state==ACCESS) & psel & penable & (counter==0).
  - pslverr = pready & range flag set.
  - prdata = mem[latched idx] when pready & ~latched pwrite & ~pslverr; otherwise 0.
- Latency: a transfer takes 2 + WAIT_STATES cycles from setup phase to completion. With WAIT_STATES=0, pready is high in the first access cycle.
- Writes commit on the completion edge:
  - For each byte b with latched pstrb[b]=1, mem byte b <= latched pwdata byte b. Bytes with pstrb[b]=0 are unchanged.
  - An out-of-range write modifies no storage.
- Address, data and control are taken from the setup-phase latch only. Changes on the bus during ACCESS are ignored.
- IDLE with psel=1 and penable=1 (access with no setup) is a protocol violation: pready = 0, no state change, no write.
- Back-to-back transfers:
  - On the completion cycle the bus moves to the next setup. The next setup-phase edge occurs in IDLE.
  - No idle cycle is required between transfers beyond the APB-mandated setup phase.
- Reset asserted mid-transfer: the FSM immediately returns to IDLE, pready and pslverr go to 0, and the memory clears. The pending write is discarded.
- Read-after-write to the same word in the next transfer returns the new data.

Test Plan:
- Reset: assert preset mid-ACCESS -> pready=0, pslverr=0, prdata=0 immediately; a subsequent read of word 3 returns 0x00000000.
- Zero-wait write then read (WAIT_STATES=0): write 0xDEADBEEF to paddr 0x08 with pstrb=4'hF -> pready=1 in the first access cycle; read of 0x08 returns 0xDEADBEEF with pslverr=0; each transfer takes 2 cycles.
- Wait states (WAIT_STATES=2): read of paddr 0x04 -> pready low for 2 access cycles and high on the 3rd; prdata is valid only on that 3rd cycle.
- Byte strobes: word 0 = 0x11223344; write 0xAABBCCDD with pstrb=4'b0101 -> a read returns 0x11BB33DD.
- Error response: write to paddr 0x40 with DEPTH=16 -> pready=1 and pslverr=1, no storage changes; a read of 0x40 returns prdata=0 with pslverr=1.
- Abort and violation: drop psel during ACCESS of a write -> IDLE, target word unchanged. Raise psel and penable together from IDLE -> no pready and no write.
